// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file for the RV32 core.
//             N_RD combinational read ports, N_WR synchronous write ports,
//             optional same-cycle write->read bypass, optional hardwired x0,
//             and a four-phase debug port (req/ack) that competes with core
//             writeback. A starving debug write raises oStallReq.
//  Ports    : iClk, nRst                 clock / async active-low reset
//             iWriteEn, iWAddr, iWData   core write ports (packed per port)
//             iRAddr, oRData             core read ports (packed per port)
//             iDbgReq, iDbgWe, iDbgAddr,
//             iDbgWData                  debug request side
//             oDbgAck, oDbgRData         debug response side
//             oStallReq                  ask the core to hold writeback
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int N_REGS       = 32,
    parameter int REG_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int N_RD         = 2,
    parameter int N_WR         = 1,
    parameter int BYPASS       = 1,
    parameter int ZERO_REG     = 1,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic                       iClk,
    input  logic                       nRst,
    input  logic [N_WR-1:0]            iWriteEn,
    input  logic [N_WR*ADDR_WIDTH-1:0] iWAddr,
    input  logic [N_WR*REG_WIDTH-1:0]  iWData,
    input  logic [N_RD*ADDR_WIDTH-1:0] iRAddr,
    output logic [N_RD*REG_WIDTH-1:0]  oRData,
    input  logic                       iDbgReq,
    input  logic                       iDbgWe,
    input  logic [ADDR_WIDTH-1:0]      iDbgAddr,
    input  logic [REG_WIDTH-1:0]       iDbgWData,
    output logic                       oDbgAck,
    output logic [REG_WIDTH-1:0]       oDbgRData,
    output logic                       oStallReq
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DBG_MAX_WAIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [REG_WIDTH-1:0]  regs [N_REGS];

    logic [1:0]            state;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [REG_WIDTH-1:0]  dbg_wdata;
    logic [CNT_W-1:0]      wait_cnt;
    logic [REG_WIDTH-1:0]  dbg_rdata;
    logic                  dbg_commit;

    // An address maps to a real, writable/readable register: in range and
    // not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < 32'(N_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a);
    endfunction

    // The debug write only commits when no core port is writing, so core and
    // debug writes are mutually exclusive by construction.
    assign dbg_commit = (state == ST_PEND) && dbg_we && !(|iWriteEn);

    // ------------------------------------------------------------------
    // Register storage. Ports are visited in ascending order so the
    // highest-index port's non-blocking assignment is the one that sticks.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            for (int r = 0; r < N_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < N_WR; p++) begin
                if (iWriteEn[p] && addr_ok(iWAddr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    regs[idx(iWAddr[p*ADDR_WIDTH +: ADDR_WIDTH])] <= iWData[p*REG_WIDTH +: REG_WIDTH];
                end
            end
            if (dbg_commit && addr_ok(dbg_addr)) begin
                regs[idx(dbg_addr)] <= dbg_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports with optional forwarding of this cycle's
    // core writes. Debug writes are never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        oRData = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (addr_ok(iRAddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                oRData[k*REG_WIDTH +: REG_WIDTH] = regs[idx(iRAddr[k*ADDR_WIDTH +: ADDR_WIDTH])];
                if (BYPASS != 0) begin
                    for (int p = 0; p < N_WR; p++) begin
                        if (iWriteEn[p] &&
                            (iWAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == iRAddr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            oRData[k*REG_WIDTH +: REG_WIDTH] = iWData[p*REG_WIDTH +: REG_WIDTH];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Debug handshake FSM: IDLE -> PEND -> ACK -> IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state     <= ST_IDLE;
            dbg_we    <= 1'b0;
            dbg_addr  <= '0;
            dbg_wdata <= '0;
            wait_cnt  <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iDbgReq) begin
                        dbg_we    <= iDbgWe;
                        dbg_addr  <= iDbgAddr;
                        dbg_wdata <= iDbgWData;
                        wait_cnt  <= '0;
                        state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!dbg_we) begin
                        // Stored value only: same-cycle core writes are not seen.
                        dbg_rdata <= addr_ok(dbg_addr) ? regs[idx(dbg_addr)] : '0;
                        state     <= ST_ACK;
                    end else if (|iWriteEn) begin
                        if (wait_cnt != CNT_SAT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!iDbgReq) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oDbgAck   = (state == ST_ACK);
    assign oDbgRData = dbg_rdata;
    // Decoded purely from flops, so it changes only on clock edges; it falls
    // on the commit edge because the FSM leaves PEND and the counter clears.
    assign oStallReq = (state == ST_PEND) && dbg_we && (wait_cnt >= CNT_SAT);

endmodule
`default_nettype wire
